// File: rtl/alu_op_encode_stage.sv
// alu_op_encode_stage
//   Decode-side producer of the ALU control bundle. Takes RV32I instruction
//   words from fetch over a valid/ready handshake, decodes them, and presents
//   registered ALU control to the execute stage one cycle later. A 2-entry
//   skid (output register plus one parked entry) keeps o_inst_ready free of
//   any combinational path from i_ready.
//
// Ports
//   i_clk, i_rst         clock (rising edge), synchronous active-high reset
//   i_flush              drop everything held and anything arriving this cycle
//   i_inst_valid/o_inst_ready, i_inst, i_pc   upstream instruction handshake
//   o_valid/i_ready      downstream decoded-control handshake
//   o_opsel, o_imm, o_op2_imm, o_op1_pc, o_pc  ALU operation and operand selects
//   o_rs1, o_rs2, o_rd, o_rd_wen               register indices, rd write enable
//   o_illegal            instruction could not be decoded (flows on for trap)
module alu_op_encode_stage #(
    parameter logic [3:0] ILLEGAL_OPSEL = 4'b1111,
    parameter bit         SKID_EN       = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_inst_valid,
    output logic        o_inst_ready,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [3:0]  o_opsel,
    output logic [31:0] o_imm,
    output logic        o_op2_imm,
    output logic        o_op1_pc,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_rd_wen,
    output logic        o_illegal
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_PASSB = 4'd10;

    typedef struct packed {
        logic [3:0]  opsel;
        logic [31:0] imm;
        logic        op2_imm;
        logic        op1_pc;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        illegal;
    } ctl_t;

    // funct3 -> ALU op for the shared R/I arithmetic map (SUB/SRA picked by funct7).
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = 4'd0;
            3'b001:  base_op = 4'd2;
            3'b010:  base_op = 4'd3;
            3'b011:  base_op = 4'd4;
            3'b100:  base_op = 4'd5;
            3'b101:  base_op = 4'd6;
            3'b110:  base_op = 4'd8;
            default: base_op = 4'd9;
        endcase
    endfunction

    function automatic ctl_t decode(input logic [31:0] inst, input logic [31:0] pc);
        ctl_t               c;
        logic               bad;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic signed [31:0] imm_i;
        logic signed [31:0] imm_s;
        logic signed [31:0] imm_b;
        logic signed [31:0] imm_j;
        logic [31:0]        imm_u;
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_u = {inst[31:12], 12'b0};
        bad       = 1'b0;
        c         = '0;
        c.pc      = pc;
        c.rs1     = inst[19:15];
        c.rs2     = inst[24:20];
        c.rd      = inst[11:7];
        c.rd_wen  = 1'b1;
        c.op2_imm = 1'b1;
        case (inst[6:0])
            7'b0110011: begin
                c.op2_imm = 1'b0;
                c.opsel   = base_op(f3);
                if (f7 == 7'b0100000 && f3 == 3'b000)      c.opsel = OP_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101) c.opsel = OP_SRA;
                else if (f7 != 7'b0000000)                 bad = 1'b1;
            end
            7'b0010011: begin
                c.opsel = base_op(f3);
                c.imm   = imm_i;
                if (f3 == 3'b001) begin
                    c.imm = {27'b0, inst[24:20]};
                    if (f7 != 7'b0000000) bad = 1'b1;
                end else if (f3 == 3'b101) begin
                    c.imm   = {27'b0, inst[24:20]};
                    c.opsel = f7[5] ? OP_SRA : OP_SRL;
                    if (f7 != 7'b0000000 && f7 != 7'b0100000) bad = 1'b1;
                end
            end
            7'b0110111: begin
                c.opsel = OP_PASSB;
                c.imm   = imm_u;
            end
            7'b0010111: begin
                c.opsel  = OP_ADD;
                c.op1_pc = 1'b1;
                c.imm    = imm_u;
            end
            7'b0000011: begin
                c.opsel = OP_ADD;
                c.imm   = imm_i;
            end
            7'b0100011: begin
                c.opsel  = OP_ADD;
                c.imm    = imm_s;
                c.rd_wen = 1'b0;
            end
            7'b1100011: begin
                c.op2_imm = 1'b0;
                c.imm     = imm_b;
                c.rd_wen  = 1'b0;
                case (f3[2:1])
                    2'b00:   c.opsel = OP_SUB;
                    2'b10:   c.opsel = OP_SLT;
                    2'b11:   c.opsel = OP_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            7'b1101111: begin
                c.opsel  = OP_ADD;
                c.op1_pc = 1'b1;
                c.imm    = imm_j;
            end
            7'b1100111: begin
                c.opsel = OP_ADD;
                c.imm   = imm_i;
                if (f3 != 3'b000) bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            c.illegal = 1'b1;
            c.opsel   = ILLEGAL_OPSEL;
            c.imm     = '0;
            c.op2_imm = 1'b0;
            c.op1_pc  = 1'b0;
            c.rd_wen  = 1'b0;
        end
        if (c.rd == 5'd0) c.rd_wen = 1'b0;
        return c;
    endfunction

    ctl_t dec_p0;
    ctl_t ctl_p1;
    ctl_t skid_p1;
    logic vld_p1;
    logic skid_vld_p1;
    logic in_xfer;

    // ---- stage p0: combinational decode of the offered word ----
    assign dec_p0  = decode(i_inst, i_pc);
    assign in_xfer = i_inst_valid & o_inst_ready;

    // With the skid, readiness depends only on local state; without it the
    // single register can refill in the same cycle it drains.
    assign o_inst_ready = ~i_rst & (SKID_EN ? ~skid_vld_p1 : (~vld_p1 | i_ready));

    // ---- stage p1: output register and skid entry ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            ctl_p1      <= '0;
            skid_p1     <= '0;
        end else if (i_flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (!vld_p1 || i_ready) begin
            // Skid is only ever full while the output register is full and
            // input is blocked, so the two sources never compete here.
            if (skid_vld_p1) begin
                ctl_p1      <= skid_p1;
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= in_xfer;
                if (in_xfer) ctl_p1 <= dec_p0;
            end
        end else if (in_xfer && SKID_EN) begin
            skid_p1     <= dec_p0;
            skid_vld_p1 <= 1'b1;
        end
    end

    assign o_valid   = vld_p1;
    assign o_opsel   = ctl_p1.opsel;
    assign o_imm     = ctl_p1.imm;
    assign o_op2_imm = ctl_p1.op2_imm;
    assign o_op1_pc  = ctl_p1.op1_pc;
    assign o_pc      = ctl_p1.pc;
    assign o_rs1     = ctl_p1.rs1;
    assign o_rs2     = ctl_p1.rs2;
    assign o_rd      = ctl_p1.rd;
    assign o_rd_wen  = ctl_p1.rd_wen;
    assign o_illegal = ctl_p1.illegal;

endmodule

// File: tb/tb_alu_op_encode_stage.sv
// Directed bench for alu_op_encode_stage: reset state, decode of several
// instruction classes, back-to-back throughput, stall with skid, flush and
// reset during a stall.
module tb_alu_op_encode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        ready;
    logic [3:0]  opsel;
    logic [31:0] imm;
    logic        op2_imm;
    logic        op1_pc;
    logic [31:0] pc_out;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_op_encode_stage dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_inst_valid (inst_valid),
        .o_inst_ready (inst_ready),
        .i_inst       (inst),
        .i_pc         (pc),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_opsel      (opsel),
        .o_imm        (imm),
        .o_op2_imm    (op2_imm),
        .o_op1_pc     (op1_pc),
        .o_pc         (pc_out),
        .o_rs1        (rs1),
        .o_rs2        (rs2),
        .o_rd         (rd),
        .o_rd_wen     (rd_wen),
        .o_illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and checks happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] p);
        inst_valid = 1'b1;
        inst       = w;
        pc         = p;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; inst_valid = 1'b0; inst = '0; pc = '0; ready = 1'b1;
        tick(); tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_opsel", 32'(opsel), 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_ready_low", 32'(inst_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(inst_ready), 32'd1);

        // ADD x3,x1,x2
        offer(32'h002081B3, 32'h100);
        tick();
        check("add_valid", 32'(valid), 32'd1);
        check("add_opsel", 32'(opsel), 32'd0);
        check("add_rs1", 32'(rs1), 32'd1);
        check("add_rs2", 32'(rs2), 32'd2);
        check("add_rd", 32'(rd), 32'd3);
        check("add_wen", 32'(rd_wen), 32'd1);
        check("add_op2imm", 32'(op2_imm), 32'd0);
        check("add_pc", pc_out, 32'h100);

        // SUB then SRAI x5,x6,3 back-to-back
        offer(32'h402081B3, 32'h104);
        tick();
        check("sub_valid", 32'(valid), 32'd1);
        check("sub_opsel", 32'(opsel), 32'd1);
        offer(32'h40335293, 32'h108);
        tick();
        check("srai_valid", 32'(valid), 32'd1);
        check("srai_opsel", 32'(opsel), 32'd7);
        check("srai_imm", imm, 32'd3);
        check("srai_op2imm", 32'(op2_imm), 32'd1);
        check("srai_rs1", 32'(rs1), 32'd6);
        check("srai_rd", 32'(rd), 32'd5);

        // LUI x1,0x12345
        offer(32'h123450B7, 32'h10C);
        tick();
        check("lui_opsel", 32'(opsel), 32'd10);
        check("lui_imm", imm, 32'h12345000);
        check("lui_wen", 32'(rd_wen), 32'd1);

        // All-zero word is not decodable
        offer(32'h00000000, 32'h110);
        tick();
        check("ill_valid", 32'(valid), 32'd1);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_opsel", 32'(opsel), 32'hF);
        check("ill_wen", 32'(rd_wen), 32'd0);
        check("ill_imm", imm, 32'd0);

        // BEQ x1,x2,+8
        offer(32'h00208463, 32'h114);
        tick();
        check("beq_opsel", 32'(opsel), 32'd1);
        check("beq_imm", imm, 32'd8);
        check("beq_wen", 32'(rd_wen), 32'd0);
        check("beq_op2imm", 32'(op2_imm), 32'd0);
        check("beq_illegal", 32'(illegal), 32'd0);

        // ADDI x1,x0,-1
        offer(32'hFFF00093, 32'h118);
        tick();
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_opsel", 32'(opsel), 32'd0);

        // AUIPC x2,1
        offer(32'h00001117, 32'h11C);
        tick();
        check("auipc_op1pc", 32'(op1_pc), 32'd1);
        check("auipc_imm", imm, 32'h00001000);
        check("auipc_opsel", 32'(opsel), 32'd0);

        // ADD x0,x1,x2 writes nothing
        offer(32'h00208033, 32'h120);
        tick();
        check("rd0_wen", 32'(rd_wen), 32'd0);
        inst_valid = 1'b0;
        tick();
        check("idle_valid", 32'(valid), 32'd0);

        // Stall: three offers while execute is blocked
        ready = 1'b0;
        offer(32'h002081B3, 32'h200);
        tick();
        check("stall_a_valid", 32'(valid), 32'd1);
        check("stall_a_pc", pc_out, 32'h200);
        check("stall_ready1", 32'(inst_ready), 32'd1);
        offer(32'h402081B3, 32'h204);
        tick();
        check("stall_ready2", 32'(inst_ready), 32'd0);
        check("stall_hold_pc", pc_out, 32'h200);
        offer(32'h123450B7, 32'h208);
        tick();
        check("stall_ready3", 32'(inst_ready), 32'd0);
        check("stall_hold_pc2", pc_out, 32'h200);
        check("stall_hold_op", 32'(opsel), 32'd0);
        ready = 1'b1;
        tick();
        check("drain_b_pc", pc_out, 32'h204);
        check("drain_b_opsel", 32'(opsel), 32'd1);
        check("drain_ready", 32'(inst_ready), 32'd1);
        tick();
        check("drain_c_pc", pc_out, 32'h208);
        check("drain_c_opsel", 32'(opsel), 32'd10);
        inst_valid = 1'b0;
        tick();
        check("drain_idle", 32'(valid), 32'd0);

        // Flush with skid full and an instruction on the input
        ready = 1'b0;
        offer(32'h002081B3, 32'h300);
        tick();
        offer(32'h402081B3, 32'h304);
        tick();
        check("fl_skid_full", 32'(inst_ready), 32'd0);
        flush = 1'b1;
        offer(32'h123450B7, 32'h308);
        tick();
        check("fl_valid", 32'(valid), 32'd0);
        check("fl_ready", 32'(inst_ready), 32'd1);
        flush = 1'b0; inst_valid = 1'b0; ready = 1'b1;
        tick();
        check("fl_nothing1", 32'(valid), 32'd0);
        tick();
        check("fl_nothing2", 32'(valid), 32'd0);

        // Reset during a stall
        ready = 1'b0;
        offer(32'h002081B3, 32'h400);
        tick();
        offer(32'h402081B3, 32'h404);
        tick();
        rst = 1'b1; inst_valid = 1'b0;
        tick();
        check("mrst_valid", 32'(valid), 32'd0);
        check("mrst_pc", pc_out, 32'd0);
        check("mrst_rd", 32'(rd), 32'd0);
        check("mrst_ready", 32'(inst_ready), 32'd0);
        rst = 1'b0; ready = 1'b1;
        #1;
        check("mrst_ready_back", 32'(inst_ready), 32'd1);
        offer(32'h40335293, 32'h500);
        tick();
        check("post_valid", 32'(valid), 32'd1);
        check("post_opsel", 32'(opsel), 32'd7);
        check("post_pc", pc_out, 32'h500);
        inst_valid = 1'b0;
        tick();
        check("post_idle", 32'(valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
